// File: rtl/reservoir_sequencer.sv
// reservoir_sequencer
//   Feeds a time-multiplexed reservoir: each accepted input sample is applied
//   to VIRTUAL_NODES virtual nodes in turn, with the sign of each application
//   chosen by the input mask. After each reservoir step the settled reservoir
//   word is captured and offered downstream with its node index.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   start_i             single-cycle pulse that begins a run (honoured in IDLE only)
//   num_samples_i       samples in the run, sampled at start
//   mask_i              per-node sign mask (1: +sample, 0: -sample), sampled at start
//   sample_valid_i/     upstream sample handshake and data
//   sample_ready_o/sample_data_i
//   res_din_o, res_en_o masked sample and one-cycle step pulse to the reservoir
//   res_valid_i,        reservoir settled indication and output word
//   res_dout_i
//   out_valid_o/out_ready_i, out_data_o, out_node_o, out_last_o
//                       downstream node output handshake
//   busy_o, done_o      run in progress; one-cycle run-complete pulse
//
// States
//   IDLE   | waiting for start
//   FETCH  | sample_ready high, waiting for an upstream sample
//   DRIVE  | one-cycle reservoir step with the masked sample
//   SETTLE | waiting for res_valid, then capture res_dout
//   EMIT   | captured word offered downstream until accepted
//   DONE   | one-cycle done pulse
module reservoir_sequencer #(
  parameter int VIRTUAL_NODES = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  input  logic [CNT_WIDTH-1:0]             num_samples_i,
  input  logic [VIRTUAL_NODES-1:0]         mask_i,
  input  logic                             sample_valid_i,
  input  logic [DATA_WIDTH-1:0]            sample_data_i,
  output logic                             sample_ready_o,
  output logic [DATA_WIDTH-1:0]            res_din_o,
  output logic                             res_en_o,
  input  logic                             res_valid_i,
  input  logic [DATA_WIDTH-1:0]            res_dout_i,
  output logic                             out_valid_o,
  output logic [DATA_WIDTH-1:0]            out_data_o,
  output logic [$clog2(VIRTUAL_NODES)-1:0] out_node_o,
  output logic                             out_last_o,
  input  logic                             out_ready_i,
  output logic                             busy_o,
  output logic                             done_o
);

  localparam int NODE_W = $clog2(VIRTUAL_NODES);
  localparam logic [NODE_W-1:0]    LAST_NODE = NODE_W'(VIRTUAL_NODES - 1);
  localparam logic [NODE_W-1:0]    NODE_ONE  = NODE_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRIVE,
    S_SETTLE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_WIDTH-1:0]     num_q, num_d;
  logic [VIRTUAL_NODES-1:0] mask_q, mask_d;
  logic [NODE_W-1:0]        node_q, node_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    sample_q, sample_d;
  logic [DATA_WIDTH-1:0]    res_din_q, res_din_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic [NODE_W-1:0]        out_node_q, out_node_d;
  logic                     out_last_q, out_last_d;
  logic                     sample_ready_q, res_en_q, out_valid_q, busy_q, done_q;
  logic                     last_sample;

  function automatic logic [DATA_WIDTH-1:0] apply_mask(input logic pos,
                                                       input logic [DATA_WIDTH-1:0] v);
    return pos ? v : -v;
  endfunction

  // num_q is never zero while a run is active, so num_q-1 cannot underflow.
  assign last_sample = (cnt_q == num_q - CNT_ONE);

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    mask_d     = mask_q;
    node_d     = node_q;
    cnt_d      = cnt_q;
    sample_d   = sample_q;
    res_din_d  = res_din_q;
    out_data_d = out_data_q;
    out_node_d = out_node_q;
    out_last_d = out_last_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (num_samples_i != '0) begin
            num_d   = num_samples_i;
            mask_d  = mask_i;
            node_d  = '0;
            cnt_d   = '0;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        // sample_ready_o is high for the whole of FETCH
        if (sample_valid_i) begin
          sample_d  = sample_data_i;
          res_din_d = apply_mask(mask_q[0], sample_data_i);
          state_d   = S_DRIVE;
        end
      end
      S_DRIVE: begin
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (res_valid_i) begin
          out_data_d = res_dout_i;
          out_node_d = node_q;
          out_last_d = (node_q == LAST_NODE) && last_sample;
          state_d    = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready_i) begin
          out_last_d = 1'b0;
          if (node_q != LAST_NODE) begin
            node_d    = node_q + NODE_ONE;
            res_din_d = apply_mask(mask_q[node_q + NODE_ONE], sample_q);
            state_d   = S_DRIVE;
          end else begin
            node_d  = '0;
            cnt_d   = cnt_q + CNT_ONE;
            state_d = last_sample ? S_DONE : S_FETCH;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status outputs are registered copies of the next state, so they line up
  // exactly with the state the FSM is in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      num_q          <= '0;
      mask_q         <= '0;
      node_q         <= '0;
      cnt_q          <= '0;
      sample_q       <= '0;
      res_din_q      <= '0;
      out_data_q     <= '0;
      out_node_q     <= '0;
      out_last_q     <= 1'b0;
      sample_ready_q <= 1'b0;
      res_en_q       <= 1'b0;
      out_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      num_q          <= num_d;
      mask_q         <= mask_d;
      node_q         <= node_d;
      cnt_q          <= cnt_d;
      sample_q       <= sample_d;
      res_din_q      <= res_din_d;
      out_data_q     <= out_data_d;
      out_node_q     <= out_node_d;
      out_last_q     <= out_last_d;
      sample_ready_q <= (state_d == S_FETCH);
      res_en_q       <= (state_d == S_DRIVE);
      out_valid_q    <= (state_d == S_EMIT);
      busy_q         <= (state_d != S_IDLE);
      done_q         <= (state_d == S_DONE);
    end
  end

  assign sample_ready_o = sample_ready_q;
  assign res_din_o      = res_din_q;
  assign res_en_o       = res_en_q;
  assign out_valid_o    = out_valid_q;
  assign out_data_o     = out_data_q;
  assign out_node_o     = out_node_q;
  assign out_last_o     = out_last_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: doc/reservoir_sequencer.md
RESERVOIR_SEQUENCER -- requirements
Module: reservoir_sequencer

Interface
REQ-001 Parameters SHALL be:
- VIRTUAL_NODES, 10, number of virtual nodes per input sample.
- DATA_WIDTH, 32, sample and reservoir word width.
- CNT_WIDTH, 16, width of the sample counter.
REQ-002 Ports SHALL be:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse that begins a run.
- num_samples  in  CNT_WIDTH  samples in the run; sampled at start.
- mask  in  VIRTUAL_NODES  input mask; bit i=1 means +sample, bit i=0 means -sample; sampled at start.
- sample_valid  in  1  upstream sample available.
- sample_data  in  DATA_WIDTH  upstream sample, two's complement.
- sample_ready  out  1  sequencer accepts a sample.
- res_din  out  DATA_WIDTH  masked sample driven to the reservoir.
- res_en  out  1  one-cycle reservoir step pulse.
- res_valid  in  1  reservoir idle/settled indication.
- res_dout  in  DATA_WIDTH  reservoir output word.
- out_valid  out  1  node output available.
- out_data  out  DATA_WIDTH  captured reservoir output.
- out_node  out  $clog2(VIRTUAL_NODES)  virtual node index of out_data.
- out_last  out  1  out_data is the final word of the run.
- out_ready  in  1  downstream accepts output.
- busy  out  1  a run is in progress.
- done  out  1  one-cycle run-complete pulse.

Function
REQ-003 States SHALL be IDLE, FETCH, DRIVE, SETTLE, EMIT and DONE; all outputs SHALL be registered.
REQ-004 IDLE: on start with num_samples>0, latch num_samples and mask, clear node_idx and sample_cnt, go to FETCH; on start with num_samples==0, go to DONE.
REQ-005 start SHALL be ignored outside IDLE.
REQ-006 FETCH: sample_ready=1; on sample_valid&&sample_ready, register sample_data and go to DRIVE.
REQ-007 DRIVE lasts exactly one cycle with res_en=1. res_din SHALL equal the sample when mask[node_idx]=1, else its two's-complement negation, modulo 2^DATA_WIDTH.
REQ-008 res_din SHALL be valid in DRIVE and held stable through SETTLE.
REQ-009 SETTLE: res_en=0; the first cycle with res_valid=1 SHALL capture res_dout into out_data and node_idx into out_node, then go to EMIT. SETTLE SHALL wait indefinitely while res_valid=0.
REQ-010 EMIT: out_valid=1, with out_data, out_node and out_last held stable until out_valid&&out_ready.
REQ-011 On the EMIT handshake:
- if node_idx<VIRTUAL_NODES-1: increment node_idx, go to DRIVE, reusing the held sample.
- otherwise: clear node_idx and increment sample_cnt; go to DONE if sample_cnt+1==num_samples, else go to FETCH.
REQ-012 out_last SHALL be 1 only in EMIT when node_idx==VIRTUAL_NODES-1 and sample_cnt==num_samples-1.
REQ-013 DONE: done=1 for exactly one cycle, then IDLE.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 Minimum node-step latency SHALL be 3 cycles (DRIVE, SETTLE, EMIT) with res_valid and out_ready held high. Minimum run length SHALL be num_samples*(1+3*VIRTUAL_NODES)+1 cycles from start to the done pulse.
REQ-016 sample_cnt SHALL not wrap; the maximum num_samples is 2^CNT_WIDTH-1.

Reset
REQ-017 rst=1 SHALL immediately force IDLE and clear every output to 0 (sample_ready, res_en, res_din, out_valid, out_data, out_node, out_last, busy, done) and all internal counters and registers.
REQ-018 Reset mid-run SHALL abort the run without a done pulse; the first start after rst deasserts begins a fresh run.

Verification
REQ-019 Scenario: num_samples=1, mask=10'b1111111111, sample=0x00000100, res_valid and out_ready tied 1 -> 10 outputs with out_node 0..9, res_din=0x00000100 at each res_en, out_last only on node 9, done 32 cycles after start.
REQ-020 Scenario: mask=10'b0000000001, sample=0x00000005 -> res_din=0x00000005 for node 0 and 0xFFFFFFFB for nodes 1..9.
REQ-021 Scenario: start with num_samples=0 -> done pulses 1 cycle after start; res_en and out_valid never assert.
REQ-022 Scenario: out_ready held 0 for 5 cycles in EMIT -> out_valid, out_data and out_node stay stable; no res_en until the handshake completes.
REQ-023 Scenario: res_valid held 0 for 4 cycles after res_en -> SETTLE holds and res_din stays stable; out_data equals res_dout from the first res_valid=1 cycle.
REQ-024 Scenario: rst asserted during the sample 2 of 3 EMIT -> all outputs 0 in the same cycle, no done; a new start with num_samples=2 completes normally with 20 outputs.
